addsub32_seq: RTL and testbench
===============================

ADDSUB32_SEQ -- requirements
Module: addsub32_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed: operands and result 32 bits, byte slice 8 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a new operation; sampled on rising edge.
REQ-005 mode  input  1  0 = add (A+B), 1 = subtract (A-B); latched with operands.
REQ-006 a  input  32  operand A; latched when start is accepted.
REQ-007 b  input  32  operand B; latched when start is accepted.
REQ-008 busy  output  1  high while bytes are being processed.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 s  output  32  result; held from done until next accepted start or reset.
REQ-011 cout  output  1  carry out of bit 31; for subtract, 1 = no borrow.
REQ-012 ov  output  1  signed two's-complement overflow of the 32-bit operation.

Function
REQ-013 SHALL contain exactly one 8-bit add/sub slice: {c, sum} = a_byte + (b_byte XOR {8{mode}}) + cin, reused over 4 cycles.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; encoding at implementer's choice.
REQ-015 IDLE: start=1 -> RUN, latch a/b/mode, byte index = 0, busy=1; start=0 -> stay.
REQ-016 RUN: each edge processes byte[idx] (bits 8*idx+7:8*idx), writes sum into s at that byte, stores carry, idx increments.
REQ-017 cin for byte 0 SHALL be latched mode; for bytes 1..3 the stored carry from the previous byte.
REQ-018 RUN with idx=3: after processing byte 3 -> DONE, busy=0, done=1, cout = byte-3 carry, ov set.
REQ-019 ov SHALL equal (A[31] == B'[31]) AND (S[31] != A[31]), where B' = B XOR {32{mode}}.
REQ-020 DONE lasts exactly one cycle: start=1 -> RUN with new operands (back-to-back); else -> IDLE; done returns to 0 either way.
REQ-021 Latency: counting the edge that accepts start as edge 1, done SHALL be high in the cycle after edge 5; busy high in the cycles after edges 1 to 4.
REQ-022 start while in RUN SHALL be ignored; latched operands and mode SHALL be unaffected by input changes during RUN.
REQ-023 Bytes of s not yet processed in the current operation SHALL read 0 (s cleared on accept); s, cout and ov are only guaranteed correct while done=1 and afterwards.
REQ-024 cout and ov SHALL be cleared on accept and held after DONE until the next accept.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, idx=0, stored carry=0, busy=0, done=0, s=0, cout=0, ov=0, and all latched operands = 0.
REQ-026 Reset SHALL take priority over start and abort any operation in progress; no done pulse SHALL be produced for an aborted operation.
REQ-027 Outputs SHALL be undefined before the first reset edge; the bench SHALL apply reset before the first start.

Verification
REQ-028 add 0x000000FF + 0x00000001 -> s=0x00000100, cout=0, ov=0; done after edge 5 exactly.
REQ-029 add 0xFFFFFFFF + 0x00000001 -> s=0x00000000, cout=1, ov=0; add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, cout=0, ov=1.
REQ-030 sub 0x00000000 - 0x00000001 -> s=0xFFFFFFFF, cout=0, ov=0; sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, cout=1, ov=1.
REQ-031 start pulsed again and a/b changed during RUN -> ignored, result matches the originally latched operands, single done pulse.
REQ-032 rst_n=0 at edge 3 of an operation -> next cycle busy=0, done=0, s=0; a following start 0x12345678 + 0x11111111 -> s=0x23456789, cout=0, ov=0.
REQ-033 start held high across DONE -> second operation begins with no IDLE cycle; done pulses every 5 cycles; each result correct.

Source files
------------

// File: rtl/addsub32_seq.sv
// 32-bit add/subtract that uses one 8-bit slice over four cycles.
// Bytes are processed LSB first, and the carry is chained between cycles.
module addsub32_slice (
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   input  logic       mode,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       c
);
   assign {c, sum} = {1'b0, a_byte} + {1'b0, b_byte ^ {8{mode}}} + {8'd0, cin};
endmodule

module addsub32_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] s,
   output logic        cout,
   output logic        ov
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic        mode;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   state_t     state, state_nx;
   req_t       req;
   logic [1:0] idx;
   logic       carry;
   logic       accept;
   logic [7:0] a_byte, b_byte, sum;
   logic       cin, c;

   // A start is taken only when idle or in the one-cycle DONE state (back-to-back).
   assign accept = start && ((state == IDLE) || (state == DONE));
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   assign a_byte = req.a[8*idx +: 8];
   assign b_byte = req.b[8*idx +: 8];
   assign cin    = (idx == 2'd0) ? req.mode : carry;

   addsub32_slice u_slice (
      .a_byte (a_byte),
      .b_byte (b_byte),
      .mode   (req.mode),
      .cin    (cin),
      .sum    (sum),
      .c      (c)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (idx == 2'd3) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         req   <= '0;
         idx   <= 2'd0;
         carry <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ov    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            req   <= '{mode: mode, a: a, b: b};
            idx   <= 2'd0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ov    <= 1'b0;
         end else if (state == RUN) begin
            s[8*idx +: 8] <= sum;
            carry         <= c;
            idx           <= idx + 2'd1;
            if (idx == 2'd3) begin
               cout <= c;
               // Overflow: operands share a sign that the result does not.
               ov   <= (req.a[31] == (req.b[31] ^ req.mode)) && (sum[7] != req.a[31]);
            end
         end
      end
   end
endmodule

// File: tb/tb_addsub32_seq.sv
// Directed and random checks of addsub32_seq against an arithmetic reference model.
module tb_addsub32_seq;
   logic        clk, rst_n, start, mode;
   logic [31:0] a, b;
   logic        busy, done, cout, ov;
   logic [31:0] s;

   int total = 0;
   int bad   = 0;

   addsub32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ov    (ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: 32-bit wrap result, carry = unsigned overflow / no-borrow, ov = signed range exceeded.
   task automatic model(input bit m, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rs, output logic rc, output logic rv);
      longint sx, sy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!m) begin
         rs = x + y;
         rc = ({32'd0, x} + {32'd0, y}) > 64'h0000_0000_FFFF_FFFF;
         r  = sx + sy;
      end else begin
         rs = x - y;
         rc = (x >= y);
         r  = sx - sy;
      end
      rv = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endtask

   // One operation: accept at edge 1, done after edge 5. noise scrambles inputs during RUN;
   // hold leaves start high at the end so the caller can chain another op.
   task automatic op(input bit m, input logic [31:0] x, input logic [31:0] y,
                     input bit noise, input bit hold);
      logic [31:0] es, mask;
      logic        ec, ev;
      model(m, x, y, es, ec, ev);
      start = 1'b1; mode = m; a = x; b = y;
      tick();
      chk("accept_busy", busy, 1'b1);
      chk("accept_done", done, 1'b0);
      chk("accept_s_clear", s, 32'd0);
      chk("accept_cout_clear", cout, 1'b0);
      chk("accept_ov_clear", ov, 1'b0);
      start = hold;
      for (int k = 1; k <= 3; k++) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
         end
         tick();
         mask = 32'hFFFF_FFFF >> (32 - 8 * k);
         chk("run_busy", busy, 1'b1);
         chk("run_done", done, 1'b0);
         chk("partial_s", s, es & mask);
      end
      if (hold) start = 1'b1;
      tick();
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("result_s", s, es);
      chk("result_cout", cout, ec);
      chk("result_ov", ov, ev);
      if (!hold) begin
         start = 1'b0;
         tick();
         chk("idle_done", done, 1'b0);
         chk("idle_busy", busy, 1'b0);
         chk("held_s", s, es);
         chk("held_cout", cout, ec);
         chk("held_ov", ov, ev);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_s", s, 32'd0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ov", ov, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("idle_nostart", busy, 1'b0);

      // Directed corner vectors
      op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      op(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
      op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);

      // Inputs and start disturbed during RUN
      op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);

      // Reset at edge 3 aborts the operation
      start = 1'b1; mode = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_s", s, 32'd0);
      chk("abort_cout", cout, 1'b0);
      chk("abort_ov", ov, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("abort_no_done", done, 1'b0);
      end
      op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

      // Back-to-back with start held across DONE
      op(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
      op(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
      op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

      // Random operations, some disturbed, some chained
      for (int i = 0; i < 40; i++) begin
         op(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), (i != 39) && ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
